if_id_hazard: RTL and testbench
===============================

Name: if_id_hazard

Overview:
- IF/ID pipeline register for the 5-stage MIPS pipeline, with integrated load-use hazard detection.
- Sits between instruction fetch (PC, instruction memory) and decode (register file, control, ID_EX register).
- Holds the fetched instruction and PC+4, and squashes them on a branch/jump redirect.
- Raises a one-cycle stall that freezes PC and IF/ID and bubbles the ID_EX control inputs.

Parameters:
- WIDTH, 32, data/instruction/PC width.
- CNT_WIDTH, 16, width of the stall and flush performance counters.
- NOP_INSTR, 32'h0000_0000, instruction loaded on flush/reset (sll $0,$0,0).

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- instruction_IF  in  WIDTH  instruction from instruction memory.
- PC_sumado_IF  in  WIDTH  PC+4 from fetch.
- flush  in  1  taken branch/jump redirect; squash the IF/ID contents.
- MemRead_EX  in  1  instruction in EX is a load.
- rt_EX  in  5  destination rt of the instruction in EX (instruction_EX[20:16]).
- instruction_ID  out  WIDTH  registered instruction to decode.
- PC_sumado_ID  out  WIDTH  registered PC+4 to decode.
- valid_ID  out  1  instruction_ID is a real, unsquashed instruction.
- stall  out  1  combinational; hold PC, hold IF/ID, zero control into ID_EX.
- stall_count  out  CNT_WIDTH  saturating count of stall cycles.
- flush_count  out  CNT_WIDTH  saturating count of flush cycles.

Behaviour:
- All register updates occur on posedge clk. Reset is synchronous, active-high.
- Reset values: instruction_ID=NOP_INSTR, PC_sumado_ID=0, valid_ID=0, stall_prev=0, stall_count=0, flush_count=0.
- Output stall is therefore 0 during the cycle after reset.
- Field decode from instruction_ID:
  - op=[31:26], rs=[25:21], rt=[20:16].
  - uses_rt=1 when op is 0 (R-type), 4 (beq), 5 (bne) or 43 (sw).
- Hazard (combinational): haz = valid_ID & MemRead_EX & (rt_EX!=0) & ((rs==rt_EX) | (uses_rt & rt==rt_EX)).
- stall = haz & ~stall_prev & ~flush.
- stall_prev register: set to stall every cycle. Guarantees at most one consecutive stall cycle, so a stale MemRead_EX can never deadlock.
- Register update priority: reset > flush > stall > load.
  - flush=1: instruction_ID<=NOP_INSTR, PC_sumado_ID<=0, valid_ID<=0, flush_count increments.
  - flush=1 with haz=1 at the same time: flush wins; stall stays 0 and stall_count does not increment.
  - stall=1: all IF/ID registers hold; stall_count increments.
  - Otherwise: instruction_ID<=instruction_IF, PC_sumado_ID<=PC_sumado_IF, valid_ID<=1.
- Latency: one cycle, IF to ID. During a stall the held instruction re-presents to decode the next cycle.
- Counters: increment by 1 and saturate at all-ones; no wrap.
- Reset mid-stall: reset wins. Registers and counters clear and stall_prev clears, so no residual stall remains.
- $0 rule: a load targeting $0 never stalls.

Decomposition:
- Shared package `mips_pkg` holds:
  - opcode constants OP_RTYPE=6'd0, OP_BEQ=6'd4, OP_BNE=6'd5, OP_SW=6'd43, OP_LW=6'd35;
  - NOP_INSTR;
  - field-slice localparams (RS_MSB/LSB, RT_MSB/LSB).
- One sub-module is natural: `load_use_detect`, purely combinational. Inputs instruction_ID, valid_ID, MemRead_EX, rt_EX; output haz.
- The pipeline register, stall_prev, counters and priority logic stay in the top module.

Test Plan:
- Plain flow: PC_sumado_IF=0x4,0x8,0xC with instruction_IF=0x012A4020,... and no hazard -> instruction_ID/PC_sumado_ID follow one cycle later, valid_ID=1, stall=0 throughout.
- Load-use on rs: instruction_ID=add $8,$9,$10 (0x012A4020), MemRead_EX=1, rt_EX=9 -> stall=1 for exactly one cycle; IF/ID holds 0x012A4020; stall_count=1. Next cycle with MemRead_EX still 1 -> stall=0 (stall_prev guard).
- rt usage: instruction_ID=sw $10,0($9) vs addi $10,$9,4, with rt_EX=10 and MemRead_EX=1 -> sw stalls; addi does not (uses_rt=0, rs=9≠10).
- $0 and no-load cases: rt_EX=0 with MemRead_EX=1 and rs=0 -> no stall. MemRead_EX=0 with matching rt -> no stall.
- Flush vs stall collision: hazard present and flush=1 in the same cycle -> next cycle instruction_ID=0x00000000, valid_ID=0; flush_count=1, stall_count unchanged. Following cycle: no stall (valid_ID=0).
- Reset and saturation:
  - Assert reset during a stall -> all outputs reach reset values on the next edge.
  - Force 65536 flush cycles -> flush_count sticks at 0xFFFF.

Source files
------------

// File: rtl/if_id_hazard_pkg.sv
// MIPS field layout and opcode constants shared by the IF/ID stage and its hazard detector.
package mips_pkg;
  localparam logic [5:0] OP_RTYPE = 6'd0;
  localparam logic [5:0] OP_BEQ   = 6'd4;
  localparam logic [5:0] OP_BNE   = 6'd5;
  localparam logic [5:0] OP_SW    = 6'd43;
  localparam logic [5:0] OP_LW    = 6'd35;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

  localparam int OP_MSB = 31;
  localparam int OP_LSB = 26;
  localparam int RS_MSB = 25;
  localparam int RS_LSB = 21;
  localparam int RT_MSB = 20;
  localparam int RT_LSB = 16;

  // Instructions that read rt as a source operand (not just as a destination).
  function automatic logic reads_rt(input logic [5:0] op);
    return (op == OP_RTYPE) || (op == OP_BEQ) || (op == OP_BNE) || (op == OP_SW);
  endfunction
endpackage

// File: rtl/if_id_hazard_if.sv
// Fetch/decode-side bundle for the IF/ID register; master drives fetch and EX info, slave is the stage.
interface if_id_hazard_if #(
  parameter int WIDTH     = 32,
  parameter int CNT_WIDTH = 16
);
  logic [WIDTH-1:0]     instruction_IF;
  logic [WIDTH-1:0]     PC_sumado_IF;
  logic                 flush;
  logic                 MemRead_EX;
  logic [4:0]           rt_EX;
  logic [WIDTH-1:0]     instruction_ID;
  logic [WIDTH-1:0]     PC_sumado_ID;
  logic                 valid_ID;
  logic                 stall;
  logic [CNT_WIDTH-1:0] stall_count;
  logic [CNT_WIDTH-1:0] flush_count;

  modport master (
    output instruction_IF, PC_sumado_IF, flush, MemRead_EX, rt_EX,
    input  instruction_ID, PC_sumado_ID, valid_ID, stall, stall_count, flush_count
  );

  modport slave (
    input  instruction_IF, PC_sumado_IF, flush, MemRead_EX, rt_EX,
    output instruction_ID, PC_sumado_ID, valid_ID, stall, stall_count, flush_count
  );
endinterface

// File: rtl/if_id_hazard_load_use_detect.sv
// Combinational load-use detector: the decoding instruction reads a register a load in EX will write.
module load_use_detect
  import mips_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] instruction_ID,
  input  logic             valid_ID,
  input  logic             MemRead_EX,
  input  logic [4:0]       rt_EX,
  output logic             haz
);
  logic [5:0] op;
  logic [4:0] rs;
  logic [4:0] rt;
  logic       uses_rt;
  logic       unused_low;

  assign op      = instruction_ID[OP_MSB:OP_LSB];
  assign rs      = instruction_ID[RS_MSB:RS_LSB];
  assign rt      = instruction_ID[RT_MSB:RT_LSB];
  assign uses_rt = reads_rt(op);

  assign unused_low = ^{instruction_ID[WIDTH-1:OP_MSB+1], instruction_ID[RT_LSB-1:0]};

  // $0 is never really written, so a load to it cannot create a dependency.
  assign haz = valid_ID && MemRead_EX && (rt_EX != 5'd0) &&
               ((rs == rt_EX) || (uses_rt && (rt == rt_EX)));
endmodule

// File: rtl/if_id_hazard.sv
// IF/ID pipeline register with flush squash, one-shot load-use stall and saturating perf counters.
module if_id_hazard
  import mips_pkg::*;
#(
  parameter int              WIDTH     = 32,
  parameter int              CNT_WIDTH = 16,
  parameter logic [WIDTH-1:0] NOP_INSTR = mips_pkg::NOP_INSTR
) (
  input logic          clk,
  input logic          reset,
  if_id_hazard_if.slave bus
);
  logic [WIDTH-1:0]     instr_q;
  logic [WIDTH-1:0]     pc_q;
  logic                 valid_q;
  logic                 stall_prev;
  logic [CNT_WIDTH-1:0] stall_cnt;
  logic [CNT_WIDTH-1:0] flush_cnt;
  logic                 haz;
  logic                 stall;

  load_use_detect #(.WIDTH(WIDTH)) u_detect (
    .instruction_ID (instr_q),
    .valid_ID       (valid_q),
    .MemRead_EX     (bus.MemRead_EX),
    .rt_EX          (bus.rt_EX),
    .haz            (haz)
  );

  // stall_prev limits the stall to one cycle so a MemRead_EX that lingers cannot lock up fetch.
  assign stall = haz && !stall_prev && !bus.flush;

  always_ff @(posedge clk) begin
    if (reset) begin
      instr_q    <= NOP_INSTR;
      pc_q       <= '0;
      valid_q    <= 1'b0;
      stall_prev <= 1'b0;
      stall_cnt  <= '0;
      flush_cnt  <= '0;
    end else begin
      stall_prev <= stall;
      if (bus.flush) begin
        instr_q <= NOP_INSTR;
        pc_q    <= '0;
        valid_q <= 1'b0;
        if (flush_cnt != '1) flush_cnt <= flush_cnt + CNT_WIDTH'(1);
      end else if (stall) begin
        if (stall_cnt != '1) stall_cnt <= stall_cnt + CNT_WIDTH'(1);
      end else begin
        instr_q <= bus.instruction_IF;
        pc_q    <= bus.PC_sumado_IF;
        valid_q <= 1'b1;
      end
    end
  end

  assign bus.instruction_ID = instr_q;
  assign bus.PC_sumado_ID   = pc_q;
  assign bus.valid_ID       = valid_q;
  assign bus.stall          = stall;
  assign bus.stall_count    = stall_cnt;
  assign bus.flush_count    = flush_cnt;
endmodule

// File: tb/tb_if_id_hazard.sv
// Bench for if_id_hazard: directed vector table, hand sequences, random traffic vs a behavioural model.
module tb_if_id_hazard;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  if_id_hazard_if #(.WIDTH(32), .CNT_WIDTH(16)) bus ();

  if_id_hazard #(.WIDTH(32), .CNT_WIDTH(16)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_pass = 0;
  int n_total = 0;

  // Behavioural model state: what decode should currently see, plus plain integer event counts.
  logic [31:0] m_instr;
  logic [31:0] m_pc;
  bit          m_valid;
  bit          m_prev_stall;
  int          m_stalls;
  int          m_flushes;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
    else n_pass++;
  endtask

  function automatic int sat16(input int n);
    return (n > 65535) ? 65535 : n;
  endfunction

  // Does the decoding instruction read the register a load in EX is about to write?
  function automatic bit mdl_stall(input bit fl, input bit mr, input int rte);
    int op, rs, rt;
    bit reads_rt;
    op = int'(m_instr >> 26);
    rs = int'((m_instr >> 21) % 32);
    rt = int'((m_instr >> 16) % 32);
    reads_rt = (op == 0) || (op == 4) || (op == 5) || (op == 43);
    if (!m_valid || !mr || rte == 0 || fl || m_prev_stall) return 1'b0;
    return (rs == rte) || (reads_rt && rt == rte);
  endfunction

  // One clock: drive inputs, sample stall mid-cycle, advance model at the edge, sample registers after it.
  task automatic step(input bit rst, input logic [31:0] i_if, input logic [31:0] p_if, input bit fl,
                      input bit mr, input logic [4:0] rte, input bit chk, output logic st_seen);
    bit exp_st;
    reset              = rst;
    bus.instruction_IF = i_if;
    bus.PC_sumado_IF   = p_if;
    bus.flush          = fl;
    bus.MemRead_EX     = mr;
    bus.rt_EX          = rte;
    @(negedge clk);
    st_seen = bus.stall;
    exp_st  = mdl_stall(fl, mr, int'(rte));
    if (chk) check("stall", {31'b0, st_seen}, {31'b0, exp_st});
    @(posedge clk);
    if (rst) begin
      m_instr = 32'h0; m_pc = 32'h0; m_valid = 0; m_prev_stall = 0; m_stalls = 0; m_flushes = 0;
    end else if (fl) begin
      m_instr = 32'h0; m_pc = 32'h0; m_valid = 0; m_prev_stall = 0; m_flushes++;
    end else if (exp_st) begin
      m_prev_stall = 1; m_stalls++;
    end else begin
      m_instr = i_if; m_pc = p_if; m_valid = 1; m_prev_stall = 0;
    end
    #1;
    if (chk) begin
      check("instruction_ID", bus.instruction_ID, m_instr);
      check("PC_sumado_ID", bus.PC_sumado_ID, m_pc);
      check("valid_ID", {31'b0, bus.valid_ID}, {31'b0, m_valid});
      check("stall_count", {16'b0, bus.stall_count}, 32'(sat16(m_stalls)));
      check("flush_count", {16'b0, bus.flush_count}, 32'(sat16(m_flushes)));
    end
  endtask

  typedef struct {
    logic [31:0] i_if;
    logic [31:0] p_if;
    bit          fl;
    bit          mr;
    logic [4:0]  rte;
    bit          e_stall;
    logic [31:0] e_instr;
    logic [31:0] e_pc;
    bit          e_valid;
    logic [15:0] e_scnt;
    logic [15:0] e_fcnt;
  } vec_t;

  vec_t vecs[10];

  initial begin
    logic st;
    logic [5:0] ops[6];

    // add $8,$9,$10 = 012A4020, sw $10,0($9) = AD2A0000, addi $10,$9,4 = 212A0004, add $8,$0,$0 = 00004020
    vecs[0] = '{32'h012A4020, 32'h04, 0, 0, 5'd0,  0, 32'h012A4020, 32'h04, 1, 16'd0, 16'd0};
    vecs[1] = '{32'h8D2A0004, 32'h08, 0, 1, 5'd9,  1, 32'h012A4020, 32'h04, 1, 16'd1, 16'd0};
    vecs[2] = '{32'hAD2A0000, 32'h08, 0, 1, 5'd9,  0, 32'hAD2A0000, 32'h08, 1, 16'd1, 16'd0};
    vecs[3] = '{32'h212A0004, 32'h0C, 0, 1, 5'd10, 1, 32'hAD2A0000, 32'h08, 1, 16'd2, 16'd0};
    vecs[4] = '{32'h212A0004, 32'h0C, 0, 0, 5'd10, 0, 32'h212A0004, 32'h0C, 1, 16'd2, 16'd0};
    vecs[5] = '{32'h00004020, 32'h10, 0, 1, 5'd10, 0, 32'h00004020, 32'h10, 1, 16'd2, 16'd0};
    vecs[6] = '{32'h012A4020, 32'h14, 0, 1, 5'd0,  0, 32'h012A4020, 32'h14, 1, 16'd2, 16'd0};
    vecs[7] = '{32'h012A4020, 32'h18, 0, 0, 5'd9,  0, 32'h012A4020, 32'h18, 1, 16'd2, 16'd0};
    vecs[8] = '{32'hDEADBEEF, 32'h1C, 1, 1, 5'd9,  0, 32'h00000000, 32'h00, 0, 16'd2, 16'd1};
    vecs[9] = '{32'h012A4020, 32'h20, 0, 1, 5'd9,  0, 32'h012A4020, 32'h20, 1, 16'd2, 16'd1};

    reset = 1;
    bus.instruction_IF = '0; bus.PC_sumado_IF = '0; bus.flush = 0; bus.MemRead_EX = 0; bus.rt_EX = '0;
    m_instr = 0; m_pc = 0; m_valid = 0; m_prev_stall = 0; m_stalls = 0; m_flushes = 0;
    @(posedge clk); #1;
    step(1, 32'h012A4020, 32'h4, 0, 1, 5'd9, 0, st);
    check("rst instruction_ID", bus.instruction_ID, 32'h0);
    check("rst PC_sumado_ID", bus.PC_sumado_ID, 32'h0);
    check("rst valid_ID", {31'b0, bus.valid_ID}, 32'h0);
    check("rst counts", {bus.stall_count, bus.flush_count}, 32'h0);

    for (int k = 0; k < 10; k++) begin
      step(0, vecs[k].i_if, vecs[k].p_if, vecs[k].fl, vecs[k].mr, vecs[k].rte, 0, st);
      check($sformatf("vec%0d stall", k), {31'b0, st}, {31'b0, vecs[k].e_stall});
      check($sformatf("vec%0d instruction_ID", k), bus.instruction_ID, vecs[k].e_instr);
      check($sformatf("vec%0d PC_sumado_ID", k), bus.PC_sumado_ID, vecs[k].e_pc);
      check($sformatf("vec%0d valid_ID", k), {31'b0, bus.valid_ID}, {31'b0, vecs[k].e_valid});
      check($sformatf("vec%0d counts", k), {bus.stall_count, bus.flush_count},
            {vecs[k].e_scnt, vecs[k].e_fcnt});
    end

    // Reset asserted while a stall is being raised: everything clears, no leftover stall.
    step(1, 32'h11111111, 32'h24, 0, 1, 5'd9, 0, st);
    check("stall before reset", {31'b0, st}, 32'h1);
    check("midstall rst instruction_ID", bus.instruction_ID, 32'h0);
    check("midstall rst valid_ID", {31'b0, bus.valid_ID}, 32'h0);
    check("midstall rst counts", {bus.stall_count, bus.flush_count}, 32'h0);
    step(0, 32'h012A4020, 32'h28, 0, 1, 5'd9, 0, st);
    check("no stall after reset", {31'b0, st}, 32'h0);

    // Randomised traffic on a small register set so dependencies are frequent.
    ops = '{6'd0, 6'd4, 6'd5, 6'd43, 6'd35, 6'd8};
    for (int n = 0; n < 3000; n++) begin
      logic [31:0] ins;
      ins = {ops[$urandom_range(0, 5)], 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
             16'($urandom)};
      step(($urandom_range(0, 63) == 0), ins, $urandom, ($urandom_range(0, 7) == 0),
           1'($urandom), 5'($urandom_range(0, 3)), 1, st);
    end

    // Saturation: hold flush long enough to overrun the 16-bit counter.
    step(1, 32'h0, 32'h0, 0, 0, 5'd0, 0, st);
    for (int n = 0; n < 65540; n++) step(0, 32'h012A4020, 32'h4, 1, 0, 5'd0, 0, st);
    check("flush_count saturated", {16'b0, bus.flush_count}, 32'h0000FFFF);
    step(0, 32'h012A4020, 32'h4, 1, 1, 5'd9, 1, st);
    check("flush_count sticks", {16'b0, bus.flush_count}, 32'h0000FFFF);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
